vend_seq_ctrl: RTL
==================

// Module: vend_seq_ctrl
// PURPOSE
//  Sequencing controller for the 7-slot vending stock datapath. It owns the per-slot stock counters.
//  It runs the purchase flow (select -> pay -> dispense -> change) and the restock flow (select -> add).
//  Sale and restock requests are arbitrated so that only one transaction touches the counters per cycle.
//  It sits between the keypad/coin front-end and the display/actuator logic.
// PARAMETERS
//  NUM_SLOTS    7     number of product slots; slot indices are 1..NUM_SLOTS, and 0 is invalid
//  CNT_W        3     stock counter width; a slot is full at 2**CNT_W-1 (7)
//  MONEY_W      5     width of the credit accumulator and change output
//  PRICE        3     uniform item price, in coin units
//  TIMEOUT_CYC  1000  idle cycles allowed in PAY before refund (TIMEOUT_EN only)
// PORTS
//  clk          in   1          rising-edge clock
//  reset        in   1          reset, synchronous, active-high
//  supply       in   1          1 = restock mode, 0 = sale mode; sampled only in IDLE
//  req_valid    in   1          request strobe; accepted when req_ready=1
//  req_ready    out  1          1 only in IDLE
//  num          in   3          slot index for the request
//  add_qty      in   CNT_W      restock quantity (restock mode)
//  coin_valid   in   1          one-cycle coin pulse
//  coin_val     in   MONEY_W    value of the inserted coin
//  cancel       in   1          abort an open purchase
//  count_flat   out  NUM_SLOTS*CNT_W  stock counts; slot k occupies bits [k*CNT_W-1 -: CNT_W]
//  maxsupply    out  CNT_W      7 - count[num] while supply=1 and 1<=num<=7; 0 otherwise
//  credit       out  MONEY_W    credit inserted so far
//  dispense     out  1          one-cycle pulse; item released
//  disp_slot    out  3          slot being dispensed; valid when dispense=1
//  change_valid out  1          one-cycle pulse returning change_amt
//  change_amt   out  MONEY_W    change or refund value
//  err          out  1          one-cycle pulse: bad slot, sold out, or over-full restock
// BEHAVIOUR
//  Reset: all counts=0, state=IDLE, credit=0, and all pulses=0. Reset mid-transaction discards credit with no refund.
//  States: IDLE, PAY, DISPENSE, CHANGE, SUPPLY.
//  IDLE, req_valid=1:
//   - num==0 -> err, stay in IDLE.
//   - supply=0: count[num]==0 -> err; otherwise latch the slot and go to PAY.
//   - supply=1: add_qty > 7-count[num] -> err with no change to the count; otherwise go to SUPPLY.
//  SUPPLY (1 cycle): count[slot] += add_qty, then return to IDLE. A restock to exactly 7 is legal.
//  PAY:
//   - Each coin_valid adds coin_val to credit. The sum saturates at 2**MONEY_W-1.
//   - When credit >= PRICE, go to DISPENSE. This is checked the cycle after the coin.
//   - cancel -> change_valid with change_amt=credit, credit cleared, return to IDLE.
//   - If cancel and coin_valid arrive in the same cycle, the coin is included in the refund.
//  DISPENSE (1 cycle): dispense=1, disp_slot=slot, count[slot] -= 1.
//  CHANGE (1 cycle): change_valid=1, change_amt=credit-PRICE (0 is still pulsed), credit=0, return to IDLE.
//  Coins arriving outside PAY are ignored and no credit is accumulated.
//  Counts never wrap. Decrement happens only when count>0 (guaranteed at entry). Increment is pre-checked.
//  Latency: restock is visible on count_flat 2 cycles after acceptance.
//  Latency: dispense pulses 2 cycles after the paying coin.
//  maxsupply is combinational from the current counts.
// CONFIGURATION
//  TIMEOUT_EN defined:
//   - A counter runs in PAY and resets on every coin.
//   - When it reaches TIMEOUT_CYC, the block behaves as cancel: refund the credit and return to IDLE.
//   - With credit=0, it returns to IDLE and still pulses change_valid with 0.
//  TIMEOUT_EN undefined: PAY waits indefinitely, and the counter logic is absent.
// STRUCTURE
//  Package vend_pkg holds:
//   - state enum/localparams
//   - NUM_SLOTS, CNT_W, MONEY_W, and CNT_MAX=2**CNT_W-1
//   - slot index check function
//  Sub-module vend_stock_regs holds the counter array: one write port (inc/dec/qty), count_flat, and the maxsupply mux.
//  The FSM, credit, and timeout logic stay in vend_seq_ctrl.
// TESTING
//  1. Reset, then restock slot 3 with qty 5 -> count3=5, maxsupply(num=3,supply=1)=2, no err.
//  2. With count3=5, restock slot 3 with qty 3 -> err pulse, count3 stays 5.
//  3. Buy slot 3 with coins 2,2 -> dispense with disp_slot=3, count3=4, change_amt=1.
//  4. Buy slot 5 when count5=0 -> err, req_ready stays 1. num=0 -> err.
//  5. Buy slot 3, insert coin 1, then cancel -> change_amt=1, count3 unchanged. Coin+cancel in one cycle -> refund 2.
//  6. TIMEOUT_EN with TIMEOUT_CYC=10, coin 1, then idle 10 cycles -> refund 1, IDLE.
//     Also apply reset in PAY -> credit=0 and all counts 0.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types, sizing constants and helpers for the vending sequencer.
package vend_pkg;

    localparam int unsigned NUM_SLOTS       = 7;
    localparam int unsigned SLOT_W          = 3;
    localparam int unsigned SLOT_W1         = SLOT_W + 1;
    localparam int unsigned CNT_W           = 3;
    localparam int unsigned CNT_MAX         = (1 << CNT_W) - 1;
    localparam int unsigned MONEY_W         = 5;
    localparam int unsigned PRICE           = 3;
    localparam int unsigned TIMEOUT_CYC_DEF = 1000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PAY,
        ST_DISPENSE,
        ST_CHANGE,
        ST_SUPPLY
    } state_e;

    // Slot indices run 1..NUM_SLOTS; zero is reserved as invalid.
    function automatic logic slot_ok(input logic [SLOT_W-1:0] n);
        return (n != '0) && ({1'b0, n} <= SLOT_W1'(NUM_SLOTS));
    endfunction

    function automatic logic [MONEY_W-1:0] sat_add(input logic [MONEY_W-1:0] a,
                                                   input logic [MONEY_W-1:0] b);
        logic [MONEY_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[MONEY_W] ? '1 : s[MONEY_W-1:0];
    endfunction

endpackage

// File: rtl/vend_stock_regs.sv
// Per-slot stock counters with a single inc/dec write port and the restock headroom mux.
module vend_stock_regs
    import vend_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic                       wr_inc,
    input  logic [SLOT_W-1:0]          wr_slot,
    input  logic [CNT_W-1:0]           wr_qty,
    input  logic                       supply,
    input  logic [SLOT_W-1:0]          num,
    output logic [NUM_SLOTS*CNT_W-1:0] count_flat,
    output logic [CNT_W-1:0]           sel_cnt_c,
    output logic [CNT_W-1:0]           maxsupply
);

    logic [CNT_W-1:0] cnt_q [1:NUM_SLOTS];

    // Increments are range-checked by the sequencer; decrements are guarded so counts never wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k <= NUM_SLOTS; k++) cnt_q[k] <= '0;
        end else if (wr_en) begin
            for (int k = 1; k <= NUM_SLOTS; k++) begin
                if (wr_slot == SLOT_W'(k)) begin
                    if (wr_inc)                cnt_q[k] <= cnt_q[k] + wr_qty;
                    else if (cnt_q[k] != '0)   cnt_q[k] <= cnt_q[k] - CNT_W'(1);
                end
            end
        end
    end

    for (genvar k = 1; k <= NUM_SLOTS; k++) begin : g_flat
        assign count_flat[k*CNT_W-1 -: CNT_W] = cnt_q[k];
    end

    always_comb begin
        sel_cnt_c = '0;
        for (int k = 1; k <= NUM_SLOTS; k++) begin
            if (num == SLOT_W'(k)) sel_cnt_c = cnt_q[k];
        end
    end

    assign maxsupply = (supply && slot_ok(num)) ? (CNT_W'(CNT_MAX) - sel_cnt_c) : '0;

endmodule

// File: rtl/vend_seq_ctrl.sv
// Vending sequencer: purchase/restock FSM, credit accumulator and change return.
// Optional PAY inactivity refund is built when TIMEOUT_EN is defined.
module vend_seq_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
)
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       supply,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [SLOT_W-1:0]          num,
    input  logic [CNT_W-1:0]           add_qty,
    input  logic                       coin_valid,
    input  logic [MONEY_W-1:0]         coin_val,
    input  logic                       cancel,
    output logic [NUM_SLOTS*CNT_W-1:0] count_flat,
    output logic [CNT_W-1:0]           maxsupply,
    output logic [MONEY_W-1:0]         credit,
    output logic                       dispense,
    output logic [SLOT_W-1:0]          disp_slot,
    output logic                       change_valid,
    output logic [MONEY_W-1:0]         change_amt,
    output logic                       err
);

    state_e             state_q;
    logic [SLOT_W-1:0]  slot_q;
    logic [CNT_W-1:0]   qty_q;
    logic [MONEY_W-1:0] credit_q;
    logic               dispense_q;
    logic [SLOT_W-1:0]  disp_slot_q;
    logic               change_valid_q;
    logic [MONEY_W-1:0] change_amt_q;
    logic               err_q;

    logic [CNT_W-1:0]   sel_cnt_c;
    logic [MONEY_W-1:0] pay_sum_c;
    logic               timeout_c;

    vend_stock_regs u_stock (
        .clk        (clk),
        .reset      (reset),
        .wr_en      ((state_q == ST_SUPPLY) || (state_q == ST_DISPENSE)),
        .wr_inc     (state_q == ST_SUPPLY),
        .wr_slot    (slot_q),
        .wr_qty     (qty_q),
        .supply     (supply),
        .num        (num),
        .count_flat (count_flat),
        .sel_cnt_c  (sel_cnt_c),
        .maxsupply  (maxsupply)
    );

    // Credit including this cycle's coin; also the refund value when cancel coincides with a coin.
    assign pay_sum_c = coin_valid ? sat_add(credit_q, coin_val) : credit_q;

`ifdef TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMR_W-1:0] tmr_q;

    always_ff @(posedge clk) begin
        if (reset || state_q != ST_PAY || coin_valid) tmr_q <= '0;
        else                                          tmr_q <= tmr_q + TMR_W'(1);
    end

    assign timeout_c = (state_q == ST_PAY) && !coin_valid && (tmr_q == TMR_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            slot_q         <= '0;
            qty_q          <= '0;
            credit_q       <= '0;
            dispense_q     <= 1'b0;
            disp_slot_q    <= '0;
            change_valid_q <= 1'b0;
            change_amt_q   <= '0;
            err_q          <= 1'b0;
        end else begin
            dispense_q     <= 1'b0;
            change_valid_q <= 1'b0;
            err_q          <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (!slot_ok(num)) begin
                            err_q <= 1'b1;
                        end else if (!supply) begin
                            if (sel_cnt_c == '0) begin
                                err_q <= 1'b1;
                            end else begin
                                slot_q  <= num;
                                state_q <= ST_PAY;
                            end
                        end else if (add_qty > (CNT_W'(CNT_MAX) - sel_cnt_c)) begin
                            err_q <= 1'b1;
                        end else begin
                            slot_q  <= num;
                            qty_q   <= add_qty;
                            state_q <= ST_SUPPLY;
                        end
                    end
                end
                ST_SUPPLY: state_q <= ST_IDLE;
                // Abort wins over the price check so a cancelled purchase never dispenses.
                ST_PAY: begin
                    if (cancel || timeout_c) begin
                        change_valid_q <= 1'b1;
                        change_amt_q   <= pay_sum_c;
                        credit_q       <= '0;
                        state_q        <= ST_IDLE;
                    end else begin
                        credit_q <= pay_sum_c;
                        if (credit_q >= MONEY_W'(PRICE)) begin
                            dispense_q  <= 1'b1;
                            disp_slot_q <= slot_q;
                            state_q     <= ST_DISPENSE;
                        end
                    end
                end
                ST_DISPENSE: begin
                    change_valid_q <= 1'b1;
                    change_amt_q   <= credit_q - MONEY_W'(PRICE);
                    credit_q       <= '0;
                    state_q        <= ST_CHANGE;
                end
                ST_CHANGE: state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign credit       = credit_q;
    assign dispense     = dispense_q;
    assign disp_slot    = disp_slot_q;
    assign change_valid = change_valid_q;
    assign change_amt   = change_amt_q;
    assign err          = err_q;

endmodule
